golomb_decode: RTL and testbench



---
 rtl/golomb_pkg.sv | 16 +
 rtl/golomb_lzc.sv | 15 +
 rtl/golomb_decode.sv | 188 ++++++++++++++++++
 tb/tb_golomb_decode.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/golomb_pkg.sv
// Shared constants and state type for the Golomb power-of-2 codec.
package golomb_pkg;

  localparam int unsigned ESC_ZEROS = 32;
  localparam int unsigned ESC_LEN   = 50;
  localparam int unsigned MAX_K     = 14;
  localparam int unsigned LEN_W     = 7;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    ERR
  } state_t;

endpackage

// File: rtl/golomb_lzc.sv
// Combinational 33-bit leading-zero counter, saturating at 33 for an all-zero input.
module golomb_lzc (
  input  logic [32:0] i_data,
  output logic [5:0]  o_lz
);

  // Scan from LSB upwards so the highest set bit is the last one to write the count.
  always_comb begin
    o_lz = 6'd33;
    for (int i = 0; i < 33; i++) begin
      if (i_data[i]) o_lz = 6'(32 - i);
    end
  end

endmodule

// File: rtl/golomb_decode.sv
// Golomb power-of-2 bitstream decoder: one sample per cycle from a left-aligned bit buffer.
// Optional statistics counters are enabled with the GOLOMB_DEC_STATS_EN macro.
module golomb_decode
  import golomb_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IN_W  = 32,
  parameter int unsigned BUF_W = 96
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_W-1:0]      in_data_i,
  input  logic                 in_valid_i,
  input  logic                 in_last_i,
  output logic                 in_ready_o,
  input  logic [3:0]           k_i,
  input  logic                 k_valid_i,
  output logic                 k_ready_o,
  output logic [WIDTH:0]       data_o,
  output logic [LEN_W-1:0]     len_o,
  output logic                 data_valid_o,
  input  logic                 data_ready_i,
  output logic                 err_o,
`ifdef GOLOMB_DEC_STATS_EN
  output logic [31:0]          stat_samples_o,
  output logic [31:0]          stat_escapes_o,
  output logic [39:0]          stat_bits_o,
`endif
  output logic                 done_o
);

  localparam int unsigned FW = $clog2(BUF_W + 1);
  localparam int unsigned RW = WIDTH + 1;
  localparam int unsigned KW = MAX_K + 1;
  localparam int unsigned VW = RW + 20;

  state_t             r_state;
  logic [BUF_W-1:0]   r_buf;
  logic [FW-1:0]      r_fill;
  logic               r_last_seen;
  logic               r_valid;
  logic               r_err;
  logic               r_done;
  logic [RW-1:0]      r_data;
  logic [LEN_W-1:0]   r_len;

  logic [5:0]         w_lz;
  logic               w_esc;
  logic [LEN_W-1:0]   w_need;
  logic [FW-1:0]      w_need_f;
  logic [ESC_LEN-1:0] w_cw;
  logic [ESC_LEN-1:0] w_tail;
  logic [KW-1:0]      w_mask;
  logic [KW-1:0]      w_rem;
  logic [VW-1:0]      w_val;
  logic [RW-1:0]      w_raw;
  logic               w_ovf;
  logic               w_active;
  logic               w_out_free;
  logic               w_bits_ok;
  logic               w_try;
  logic               w_bad;
  logic               w_drain_end;
  logic               w_pad_bad;
  logic               w_err_now;
  logic               w_dec;
  logic               w_acc;
  logic [FW-1:0]      w_fill_c;
  logic [FW-1:0]      w_fill_n;
  logic [BUF_W-1:0]   w_buf_c;
  logic [BUF_W-1:0]   w_buf_n;
  logic [BUF_W-1:0]   w_word;
  logic               w_unused_tail;

  golomb_lzc u_lzc (
    .i_data (r_buf[BUF_W-1 -: 33]),
    .o_lz   (w_lz)
  );

  assign in_ready_o = (r_fill <= FW'(BUF_W - IN_W)) && !r_last_seen && (r_state != ERR);
  assign w_acc      = in_valid_i && in_ready_o;

  always_comb begin
    w_esc    = (w_lz == 6'(ESC_ZEROS));
    w_need   = w_esc ? LEN_W'(ESC_LEN) : (LEN_W'(w_lz) + LEN_W'(k_i) + LEN_W'(1));
    w_need_f = FW'(w_need);
    // Right-justify the codeword so its remainder (or raw escape payload) sits at the LSBs.
    w_cw     = r_buf[BUF_W-1 -: ESC_LEN];
    w_tail   = w_cw >> (LEN_W'(ESC_LEN) - w_need);
    w_mask   = (KW'(1) << k_i) - KW'(1);
    w_rem    = w_tail[KW-1:0] & w_mask;
    w_raw    = w_tail[RW-1:0];
    w_val    = (VW'(w_lz[4:0]) << k_i) | VW'(w_rem);
    w_ovf    = !w_esc && ((w_val >> RW) != '0);

    w_active   = (r_state == RUN) || (r_state == DRAIN);
    w_out_free = !r_valid || data_ready_i;
    w_bits_ok  = (r_fill >= FW'(ESC_LEN)) || (r_last_seen && (r_fill >= w_need_f));
    w_try      = w_active && k_valid_i && w_out_free && w_bits_ok;
    w_bad      = (w_try && ((w_lz == 6'd33) || (k_i > 4'(MAX_K)) || w_ovf)) ||
                 (w_active && k_valid_i && r_last_seen && (r_fill < w_need_f));
    // All-zero leftovers cannot hold a codeword; short nonzero leftovers are bad padding.
    w_drain_end = (r_state == DRAIN) && !k_valid_i;
    w_pad_bad   = w_drain_end && (r_fill < FW'(8)) && (r_buf != '0);
    w_err_now   = w_bad || w_pad_bad;
    w_dec       = w_try && !w_bad;

    w_fill_c = w_dec ? (r_fill - w_need_f) : r_fill;
    w_buf_c  = w_dec ? (r_buf << w_need) : r_buf;
    w_word   = {in_data_i, {(BUF_W - IN_W){1'b0}}};
    w_buf_n  = w_acc ? (w_buf_c | (w_word >> w_fill_c)) : w_buf_c;
    w_fill_n = w_acc ? (w_fill_c + FW'(IN_W)) : w_fill_c;
  end

  assign w_unused_tail = ^w_tail[ESC_LEN-1:RW];
  assign k_ready_o     = w_dec;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_buf       <= '0;
      r_fill      <= '0;
      r_last_seen <= 1'b0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
      r_data      <= '0;
      r_len       <= '0;
    end else begin
      r_done <= 1'b0;
      r_buf  <= w_buf_n;
      r_fill <= w_fill_n;
      if (r_valid && data_ready_i) r_valid <= 1'b0;
      if (w_dec) begin
        r_data  <= w_esc ? w_raw : w_val[RW-1:0];
        r_len   <= w_need;
        r_valid <= 1'b1;
      end
      if (w_acc && in_last_i) r_last_seen <= 1'b1;
      if (w_err_now) begin
        r_state <= ERR;
        r_err   <= 1'b1;
      end else begin
        unique case (r_state)
          IDLE:  if (w_acc) r_state <= in_last_i ? DRAIN : RUN;
          RUN:   if (w_acc && in_last_i) r_state <= DRAIN;
          DRAIN: begin
            if (w_drain_end && (r_buf == '0)) begin
              r_state     <= IDLE;
              r_done      <= 1'b1;
              r_last_seen <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign data_o       = r_data;
  assign len_o        = r_len;
  assign data_valid_o = r_valid;
  assign err_o        = r_err;
  assign done_o       = r_done;

`ifdef GOLOMB_DEC_STATS_EN
  logic [31:0] r_stat_samples;
  logic [31:0] r_stat_escapes;
  logic [39:0] r_stat_bits;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_samples <= '0;
      r_stat_escapes <= '0;
      r_stat_bits    <= '0;
    end else if (w_dec) begin
      r_stat_samples <= r_stat_samples + 32'd1;
      r_stat_escapes <= r_stat_escapes + {31'd0, w_esc};
      r_stat_bits    <= r_stat_bits + 40'(w_need);
    end
  end

  assign stat_samples_o = r_stat_samples;
  assign stat_escapes_o = r_stat_escapes;
  assign stat_bits_o    = r_stat_bits;
`endif

endmodule

// File: tb/tb_golomb_decode.sv
// Scoreboard bench for golomb_decode: a bench-side encoder builds streams and expected samples.
module tb_golomb_decode;

  localparam int IN_W = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [IN_W-1:0] in_data_i;
  logic            in_valid_i;
  logic            in_last_i;
  logic            in_ready_o;
  logic [3:0]      k_i;
  logic            k_valid_i;
  logic            k_ready_o;
  logic [16:0]     data_o;
  logic [6:0]      len_o;
  logic            data_valid_o;
  logic            data_ready_i;
  logic            err_o;
  logic            done_o;
`ifdef GOLOMB_DEC_STATS_EN
  logic [31:0]     stat_samples;
  logic [31:0]     stat_escapes;
  logic [39:0]     stat_bits;
`endif

  always #5 clk = ~clk;

  golomb_decode dut (
    .clk            (clk),
    .rst            (rst),
    .in_data_i      (in_data_i),
    .in_valid_i     (in_valid_i),
    .in_last_i      (in_last_i),
    .in_ready_o     (in_ready_o),
    .k_i            (k_i),
    .k_valid_i      (k_valid_i),
    .k_ready_o      (k_ready_o),
    .data_o         (data_o),
    .len_o          (len_o),
    .data_valid_o   (data_valid_o),
    .data_ready_i   (data_ready_i),
    .err_o          (err_o),
`ifdef GOLOMB_DEC_STATS_EN
    .stat_samples_o (stat_samples),
    .stat_escapes_o (stat_escapes),
    .stat_bits_o    (stat_bits),
`endif
    .done_o         (done_o)
  );

  typedef struct packed {
    logic [16:0] data;
    logic [6:0]  len;
  } exp_t;

  int         total = 0;
  int         bad = 0;
  exp_t       sb[$];
  bit         bits_q[$];
  logic [3:0] k_q[$];
  int         n_out;
  int         cur_run;
  int         max_run;
  int         exp_samples;
  int         exp_escapes;
  longint     exp_bits;
  bit         k_done_g;

  // Bench-side encoder: emits codeword bits, the k to present, and the expected sample.
  task automatic encode(input logic [3:0] k, input logic [16:0] v);
    int   q;
    int   kk;
    exp_t e;
    kk = int'(k);
    q  = int'(v >> k);
    if (q < 32) begin
      for (int i = 0; i < q; i++) bits_q.push_back(1'b0);
      bits_q.push_back(1'b1);
      for (int i = kk - 1; i >= 0; i--) bits_q.push_back(v[i]);
      e.len = 7'(q + 1 + kk);
    end else begin
      for (int i = 0; i < 32; i++) bits_q.push_back(1'b0);
      bits_q.push_back(1'b1);
      for (int i = 16; i >= 0; i--) bits_q.push_back(v[i]);
      e.len = 7'd50;
      exp_escapes++;
    end
    e.data = v;
    sb.push_back(e);
    k_q.push_back(k);
    exp_samples++;
    exp_bits += longint'(e.len);
  endtask

  task automatic reset_dut();
    rst          = 1'b1;
    in_valid_i   = 1'b0;
    in_last_i    = 1'b0;
    in_data_i    = '0;
    k_valid_i    = 1'b0;
    k_i          = '0;
    data_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    bits_q.delete();
    k_q.delete();
    n_out       = 0;
    max_run     = 0;
    exp_samples = 0;
    exp_escapes = 0;
    exp_bits    = 0;
  endtask

  task automatic feed(input bit toggle, input bit mark_last);
    k_done_g = 1'b0;
    fork
      begin
        int nw;
        nw = (bits_q.size() + IN_W - 1) / IN_W;
        for (int w = 0; w < nw; w++) begin
          logic [IN_W-1:0] word;
          bit acc;
          bit gave_up;
          int cyc;
          word = '0;
          for (int b = 0; b < IN_W; b++) begin
            word = word << 1;
            if (bits_q.size() > 0) word[0] = bits_q.pop_front();
          end
          in_data_i  = word;
          in_last_i  = mark_last && (w == nw - 1);
          in_valid_i = 1'b1;
          acc = 1'b0; gave_up = 1'b0; cyc = 0;
          while (!acc && !gave_up) begin
            @(negedge clk);
            if (in_ready_o) acc = 1'b1;
            else if (err_o) gave_up = 1'b1;
            else if (++cyc > 2000) begin
              total++; bad++; gave_up = 1'b1;
              $display("FAIL word_accept_timeout: in_ready=%b required 1", in_ready_o);
            end
            @(posedge clk); #1;
          end
          in_valid_i = 1'b0;
          in_last_i  = 1'b0;
          if (gave_up) break;
        end
      end
      begin
        while (k_q.size() > 0) begin
          bit hs;
          bit gave_up;
          int cyc;
          k_i = k_q[0];
          k_valid_i = 1'b1;
          hs = 1'b0; gave_up = 1'b0; cyc = 0;
          while (!hs && !gave_up) begin
            @(negedge clk);
            if (k_ready_o) hs = 1'b1;
            else if (err_o) gave_up = 1'b1;
            else if (++cyc > 2000) begin
              total++; bad++; gave_up = 1'b1;
              $display("FAIL k_consume_timeout: k_ready=%b required 1", k_ready_o);
            end
            @(posedge clk); #1;
          end
          if (gave_up) break;
          void'(k_q.pop_front());
        end
        k_valid_i = 1'b0;
        k_done_g  = 1'b1;
      end
      begin
        while (!k_done_g) begin
          @(posedge clk); #1;
          if (toggle) data_ready_i = ~data_ready_i;
        end
        data_ready_i = 1'b1;
      end
    join
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s: done_o never pulsed, required a pulse", name);
    end else begin
      @(negedge clk);
      total++;
      if (done_o !== 1'b0) begin
        bad++;
        $display("FAIL %s_pulse: done_o=%b on second cycle, required 0", name, done_o);
      end
    end
  endtask

  task automatic check_drained(input string name);
    repeat (5) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_leftover: %0d samples still expected, required 0", name, sb.size());
    end
    total++;
    if (err_o !== 1'b0) begin
      bad++;
      $display("FAIL %s_err: err_o=%b required 0", name, err_o);
    end
  endtask

  // Output monitor: pops the scoreboard on each accepted sample and checks stall stability.
  initial begin
    bit          held;
    logic [16:0] hd;
    logic [6:0]  hl;
    exp_t        e;
    held = 1'b0; hd = '0; hl = '0; cur_run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
        cur_run = 0;
      end else begin
        if (held) begin
          total++;
          if (data_valid_o !== 1'b1 || data_o !== hd || len_o !== hl) begin
            bad++;
            $display("FAIL stall_stable: valid=%b data=%h len=%0d, required valid=1 data=%h len=%0d",
                     data_valid_o, data_o, len_o, hd, hl);
          end
        end
        if (data_valid_o) cur_run++;
        else cur_run = 0;
        if (cur_run > max_run) max_run = cur_run;
        if (data_valid_o && data_ready_i) begin
          n_out++;
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_output: data=%h len=%0d, required no output", data_o, len_o);
          end else begin
            e = sb.pop_front();
            if (data_o !== e.data || len_o !== e.len) begin
              bad++;
              $display("FAIL out_sample: data=%h len=%0d, required data=%h len=%0d",
                       data_o, len_o, e.data, e.len);
            end
          end
        end
        held = data_valid_o && !data_ready_i;
        hd = data_o;
        hl = len_o;
      end
    end
  end

  task automatic test_reset();
    reset_dut();
    @(negedge clk);
    total++;
    if (data_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid: %b required 0", data_valid_o); end
    total++;
    if (data_o !== '0) begin bad++; $display("FAIL rst_data: %h required 0", data_o); end
    total++;
    if (len_o !== '0) begin bad++; $display("FAIL rst_len: %0d required 0", len_o); end
    total++;
    if (err_o !== 1'b0) begin bad++; $display("FAIL rst_err: %b required 0", err_o); end
    total++;
    if (done_o !== 1'b0) begin bad++; $display("FAIL rst_done: %b required 0", done_o); end
    total++;
    if (k_ready_o !== 1'b0) begin bad++; $display("FAIL rst_kready: %b required 0", k_ready_o); end
  endtask

  task automatic test_short();
    reset_dut();
    encode(4'd2, 17'd13);
    encode(4'd0, 17'd0);
    feed(1'b0, 1'b1);
    wait_done("short_done");
    check_drained("short");
  endtask

  task automatic test_escape();
    reset_dut();
    encode(4'd3, 17'h1FFFF);
    encode(4'd0, 17'd0);
    feed(1'b0, 1'b1);
    wait_done("esc_done");
    check_drained("esc");
  endtask

  task automatic test_boundary();
    reset_dut();
    for (int i = 0; i < 4; i++) encode(4'd4, 17'd5);
    encode(4'd14, 17'h1FFFF);
    encode(4'd14, 17'h0ABCD);
    encode(4'd2, 17'd13);
    feed(1'b1, 1'b1);
    wait_done("bnd_done");
    check_drained("bnd");
    // q=31 with k=14 does not fit in 17 bits and must be flagged.
    reset_dut();
    for (int i = 0; i < 10; i++) encode(4'd0, 17'd0);
    for (int i = 0; i < 31; i++) bits_q.push_back(1'b0);
    bits_q.push_back(1'b1);
    for (int i = 0; i < 14; i++) bits_q.push_back(1'b0);
    k_q.push_back(4'd14);
    feed(1'b0, 1'b1);
    repeat (20) @(negedge clk);
    total++;
    if (err_o !== 1'b1) begin bad++; $display("FAIL ovf_err: err_o=%b required 1", err_o); end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL ovf_prefix: %0d left, required 0", sb.size()); end
    total++;
    if (in_ready_o !== 1'b0) begin bad++; $display("FAIL ovf_ready: %b required 0", in_ready_o); end
  endtask

  task automatic test_throughput();
    reset_dut();
    for (int i = 0; i < 64; i++) encode(4'd0, 17'd0);
    feed(1'b0, 1'b1);
    wait_done("thr_done");
    check_drained("thr");
    total++;
    if (max_run != 64) begin
      bad++;
      $display("FAIL thr_run: longest valid run=%0d cycles, required 64", max_run);
    end
  endtask

  task automatic test_malformed();
    reset_dut();
    for (int i = 0; i < 64; i++) bits_q.push_back(1'b0);
    k_q.push_back(4'd0);
    feed(1'b0, 1'b1);
    repeat (10) @(negedge clk);
    total++;
    if (err_o !== 1'b1) begin bad++; $display("FAIL lz_err: err_o=%b required 1", err_o); end
    in_data_i  = 32'h8000_0000;
    in_valid_i = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready_o !== 1'b0) begin bad++; $display("FAIL lz_ready: %b required 0", in_ready_o); end
    repeat (20) @(negedge clk);
    total++;
    if (in_ready_o !== 1'b0 || err_o !== 1'b1) begin
      bad++;
      $display("FAIL lz_sticky: in_ready=%b err=%b, required 0 and 1", in_ready_o, err_o);
    end
    in_valid_i = 1'b0;
    total++;
    if (n_out != 0) begin bad++; $display("FAIL lz_outputs: %0d outputs, required 0", n_out); end
    // Start a stream, abandon it with a reset, then decode a fresh one.
    reset_dut();
    total++;
    if (err_o !== 1'b0) begin bad++; $display("FAIL rst_clears_err: %b required 0", err_o); end
    for (int i = 0; i < 32; i++) bits_q.push_back(i[0]);
    feed(1'b0, 1'b0);
    reset_dut();
    encode(4'd2, 17'd13);
    encode(4'd0, 17'd0);
    encode(4'd5, 17'd100);
    feed(1'b0, 1'b1);
    wait_done("fresh_done");
    check_drained("fresh");
  endtask

  task automatic test_bad_k();
    reset_dut();
    bits_q.push_back(1'b1);
    k_q.push_back(4'd15);
    feed(1'b0, 1'b1);
    repeat (10) @(negedge clk);
    total++;
    if (err_o !== 1'b1) begin bad++; $display("FAIL badk_err: err_o=%b required 1", err_o); end
    total++;
    if (n_out != 0 || data_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL badk_output: outputs=%0d valid=%b, required 0 and 0", n_out, data_valid_o);
    end
  endtask

`ifdef GOLOMB_DEC_STATS_EN
  task automatic test_stats();
    reset_dut();
    encode(4'd0, 17'd0);
    encode(4'd3, 17'h1FFFF);
    encode(4'd2, 17'd13);
    encode(4'd1, 17'd9);
    feed(1'b0, 1'b1);
    wait_done("stats_done");
    check_drained("stats");
    total++;
    if (stat_samples !== 32'(exp_samples)) begin
      bad++; $display("FAIL stat_samples: %0d required %0d", stat_samples, exp_samples);
    end
    total++;
    if (stat_escapes !== 32'(exp_escapes)) begin
      bad++; $display("FAIL stat_escapes: %0d required %0d", stat_escapes, exp_escapes);
    end
    total++;
    if (stat_bits !== 40'(exp_bits)) begin
      bad++; $display("FAIL stat_bits: %0d required %0d", stat_bits, exp_bits);
    end
  endtask
`endif

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_short();
    test_escape();
    test_boundary();
    test_throughput();
    test_malformed();
    test_bad_k();
`ifdef GOLOMB_DEC_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
